// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with queued LSU/MDU results
// onto the register-file write port, forcing a FIFO pop when queued work is starved.
module writeback_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alu_valid,
  input  logic [ADDR_W-1:0] i_alu_rd,
  input  logic [DATA_W-1:0] i_alu_data,
  input  logic              i_lsu_valid,
  output logic              o_lsu_ready,
  input  logic [ADDR_W-1:0] i_lsu_rd,
  input  logic [DATA_W-1:0] i_lsu_data,
  input  logic              i_mdu_valid,
  output logic              o_mdu_ready,
  input  logic [ADDR_W-1:0] i_mdu_rd,
  input  logic [DATA_W-1:0] i_mdu_data,
  output logic              o_stall_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] r_fifoRd   [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_starveCnt;
  logic              r_stallReq;
  logic [ADDR_W-1:0] r_rdAddr;
  logic [DATA_W-1:0] r_rdData;

  logic              w_full;
  logic              w_empty;
  logic              w_lsuFire;
  logic              w_mduFire;
  logic              w_push;
  logic [ADDR_W-1:0] w_pushRd;
  logic [DATA_W-1:0] w_pushData;
  logic              w_aluReq;
  logic              w_forcePop;
  logic              w_aluGrant;
  logic              w_pop;
  logic [3:0]        w_starveNext;

  // Full is judged on the current count only, so a same-edge pop never frees a slot.
  assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);

  assign o_lsu_ready = !i_rst && !w_full;
  assign o_mdu_ready = !i_rst && !w_full && !i_lsu_valid;

  assign w_lsuFire = i_lsu_valid && o_lsu_ready;
  assign w_mduFire = i_mdu_valid && o_mdu_ready;

  always_comb begin
    w_push     = 1'b0;
    w_pushRd   = i_lsu_rd;
    w_pushData = i_lsu_data;
    if (w_lsuFire) begin
      w_push = (i_lsu_rd != '0);
    end else if (w_mduFire) begin
      w_push     = (i_mdu_rd != '0);
      w_pushRd   = i_mdu_rd;
      w_pushData = i_mdu_data;
    end
  end

  // A zero ALU destination counts as no request, letting the FIFO drain that cycle.
  assign w_aluReq     = i_alu_valid && (i_alu_rd != '0);
  assign w_forcePop   = r_stallReq && !w_empty;
  assign w_aluGrant   = w_aluReq && !w_forcePop;
  assign w_pop        = !w_empty && !w_aluGrant;
  assign w_starveNext = r_starveCnt + 4'd1;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoRd[r_wrPtr]   <= w_pushRd;
      r_fifoData[r_wrPtr] <= w_pushData;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_starveCnt <= '0;
      r_stallReq  <= 1'b0;
    end else if (w_pop || w_empty) begin
      r_starveCnt <= '0;
      r_stallReq  <= 1'b0;
    end else if (w_aluGrant) begin
      r_starveCnt <= w_starveNext;
      if (w_starveNext == 4'(STARVE_LIMIT)) r_stallReq <= 1'b1;
    end
  end

  // Idle cycles drive address 0 because the register file has no write enable.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdAddr <= '0;
      r_rdData <= '0;
    end else if (w_pop) begin
      r_rdAddr <= r_fifoRd[r_rdPtr];
      r_rdData <= r_fifoData[r_rdPtr];
    end else if (w_aluGrant) begin
      r_rdAddr <= i_alu_rd;
      r_rdData <= i_alu_data;
    end else begin
      r_rdAddr <= '0;
      r_rdData <= '0;
    end
  end

  assign o_stall_req = r_stallReq;
  assign o_rd_addr   = r_rdAddr;
  assign o_rd_data   = r_rdData;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized and directed bench for writeback_arbiter: a queue-based reference model
// predicts every cycle's outputs into a scoreboard that an independent monitor drains.
module tb_writeback_arbiter;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  typedef struct {
    logic        lsuReady;
    logic        mduReady;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        stall;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        lsuValid;
  logic        lsuReady;
  logic [4:0]  lsuRd;
  logic [31:0] lsuData;
  logic        mduValid;
  logic        mduReady;
  logic [4:0]  mduRd;
  logic [31:0] mduData;
  logic        stallReq;
  logic [4:0]  rdAddr;
  logic [31:0] rdData;

  exp_t sbQ[$];
  ent_t mFifo[$];
  int   mStarve;
  bit   mStall;
  bit   mLsuAcc;
  bit   mMduAcc;
  int   assertCount;
  int   failCount;

  writeback_arbiter #(
    .DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_valid(aluValid), .i_alu_rd(aluRd), .i_alu_data(aluData),
    .i_lsu_valid(lsuValid), .o_lsu_ready(lsuReady), .i_lsu_rd(lsuRd), .i_lsu_data(lsuData),
    .i_mdu_valid(mduValid), .o_mdu_ready(mduReady), .i_mdu_rd(mduRd), .i_mdu_data(mduData),
    .o_stall_req(stallReq), .o_rd_addr(rdAddr), .o_rd_data(rdData)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and predict what the arbiter must show after the next edge.
  task automatic applyStimulus(
    input logic r, input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    exp_t e;
    ent_t inc;
    ent_t head;
    bit   haveInc;
    bit   full;
    bit   had;
    bit   aluReq;
    @(negedge clk);
    rst = r; aluValid = av; aluRd = ard; aluData = adat;
    lsuValid = lv; lsuRd = lrd; lsuData = ldat;
    mduValid = mv; mduRd = mrd; mduData = mdat;
    haveInc = 0;
    inc     = '{5'd0, 32'd0};
    mLsuAcc = 0;
    mMduAcc = 0;
    if (r) begin
      e = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0};
      mFifo.delete();
      mStarve = 0;
      mStall  = 0;
    end else begin
      full       = (mFifo.size() >= DEPTH);
      e.lsuReady = !full;
      e.mduReady = !full && !lv;
      if (lv && e.lsuReady) begin
        mLsuAcc = 1; haveInc = 1; inc = '{lrd, ldat};
      end else if (mv && e.mduReady) begin
        mMduAcc = 1; haveInc = 1; inc = '{mrd, mdat};
      end
      had    = (mFifo.size() > 0);
      aluReq = av && (ard != 5'd0);
      if (had && (mStall || !aluReq)) begin
        head    = mFifo.pop_front();
        e.addr  = head.rd;
        e.data  = head.data;
        mStarve = 0;
        mStall  = 0;
      end else if (aluReq) begin
        e.addr = ard;
        e.data = adat;
        if (had) begin
          mStarve++;
          if (mStarve == LIMIT) mStall = 1;
        end else begin
          mStarve = 0;
        end
      end else begin
        e.addr  = 5'd0;
        e.data  = 32'd0;
        mStarve = 0;
      end
      if (haveInc && inc.rd != 5'd0) mFifo.push_back(inc);
      e.stall = mStall;
    end
    sbQ.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: readys are sampled before the edge, registered outputs just after it.
  initial begin
    exp_t e;
    logic aL;
    logic aM;
    forever begin
      @(negedge clk);
      #2;
      aL = lsuReady;
      aM = mduReady;
      @(posedge clk);
      #1;
      if (sbQ.size() > 0) begin
        e = sbQ.pop_front();
        checkOutput("lsu_ready", {31'd0, aL}, {31'd0, e.lsuReady});
        checkOutput("mdu_ready", {31'd0, aM}, {31'd0, e.mduReady});
        checkOutput("rd_addr", {27'd0, rdAddr}, {27'd0, e.addr});
        checkOutput("rd_data", rdData, e.data);
        checkOutput("stall_req", {31'd0, stallReq}, {31'd0, e.stall});
      end
    end
  end

  initial begin
    logic        lPend, mPend, av, r;
    logic [4:0]  lR, mR, aR;
    logic [31:0] lD, mD, aD;
    assertCount = 0; failCount = 0;
    mStarve = 0; mStall = 0;
    rst = 1; aluValid = 0; aluRd = 0; aluData = 0;
    lsuValid = 0; lsuRd = 0; lsuData = 0; mduValid = 0; mduRd = 0; mduData = 0;

    $display("[TB] reset with all valids high");
    applyStimulus(1, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd3, 32'hC);
    applyStimulus(1, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 1, 5'd3, 32'hC);
    idle(2);

    $display("[TB] ALU only");
    applyStimulus(0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] LSU/MDU priority, ALU idle");
    lPend = 1; mPend = 1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, lPend, 5'd3, 32'h11, mPend, 5'd4, 32'h22);
      if (mLsuAcc) lPend = 0;
      if (mMduAcc) mPend = 0;
    end
    idle(3);

    $display("[TB] FIFO fill behind busy ALU");
    lPend = 1; mPend = 1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 5'(10 + k), 32'h100 + k, lPend, 5'd3, 32'h11, mPend, 5'd4, 32'h22);
      if (mLsuAcc) lPend = 0;
      if (mMduAcc) mPend = 0;
    end
    idle(4);

    $display("[TB] zero destinations");
    applyStimulus(0, 0, 0, 0, 1, 5'd0, 32'h55, 0, 0, 0);
    applyStimulus(0, 1, 5'd1, 32'h1111, 1, 5'd7, 32'h77, 0, 0, 0);
    applyStimulus(0, 1, 5'd0, 32'h2222, 0, 0, 0, 0, 0, 0);
    idle(2);

    $display("[TB] starvation");
    applyStimulus(0, 1, 5'd1, 32'h1000, 1, 5'd9, 32'h99, 0, 0, 0);
    aR = 5'd2;
    for (int k = 0; k < 7; k++) begin
      if (!mStall) aR = aR + 5'd1;
      applyStimulus(0, 1, aR, {27'd0, aR}, 0, 0, 0, 0, 0, 0);
    end
    idle(2);

    $display("[TB] reset mid-flight");
    applyStimulus(0, 1, 5'd20, 32'h20, 1, 5'd12, 32'hC0, 1, 5'd13, 32'hD0);
    applyStimulus(0, 1, 5'd21, 32'h21, 0, 0, 0, 1, 5'd13, 32'hD0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(4);

    $display("[TB] randomized traffic");
    lPend = 0; mPend = 0; av = 0; aR = 0; aD = 0;
    lR = 0; lD = 0; mR = 0; mD = 0;
    for (int i = 0; i < 400; i++) begin
      if (!mStall) begin
        av = 1'($urandom_range(0, 1));
        aR = 5'($urandom_range(0, 31));
        aD = $urandom;
      end
      if (!lPend && $urandom_range(0, 2) == 0) begin
        lPend = 1; lR = 5'($urandom_range(0, 31)); lD = $urandom;
      end
      if (!mPend && $urandom_range(0, 2) == 0) begin
        mPend = 1; mR = 5'($urandom_range(0, 31)); mD = $urandom;
      end
      r = ($urandom_range(0, 63) == 0);
      applyStimulus(r, av, aR, aD, lPend, lR, lD, mPend, mR, mD);
      if (mLsuAcc) lPend = 0;
      if (mMduAcc) mPend = 0;
    end
    idle(3);

    @(posedge clk);
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
